match_clock_scorer: RTL and testbench
=====================================

Name: match_clock_scorer

Overview:
- Match-level referee stage that sits between game_controller and vga_controller.
- Consumes the goal pulses from game_controller and keeps the team scores.
- Runs the countdown that drives the 8-bit time_left bus shown by vga_controller.
- Gates play through `playing`, requests ball re-centring after goals via `ball_reset`, and declares the end of match and the winner.

Parameters:
- CLK_FREQ_HZ, 50000000, clk cycles per game second.
- MATCH_SECONDS, 90, initial time_left value; must be 1..255.
- PAUSE_SECONDS, 2, post-goal freeze duration; must be ≥1.
- SCORE_WIDTH, 4, width of each score counter.
- MAX_SCORE, 9, score that ends the match immediately; must be ≤ 2^SCORE_WIDTH-1.

Ports:
- clk, input, 1, system clock (50 MHz).
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, synchronous start/restart request, level or pulse.
- team1_goal, input, 1, goal indication for team 1 from game_controller, synchronous to clk.
- team2_goal, input, 1, goal indication for team 2, synchronous to clk.
- time_left, output, 8, remaining match seconds.
- team1_points, output, SCORE_WIDTH, team 1 score.
- team2_points, output, SCORE_WIDTH, team 2 score.
- playing, output, 1, high only in PLAYING; enables player and ball motion.
- ball_reset, output, 1, one-cycle pulse that re-centres ball and players.
- second_tick, output, 1, one-cycle pulse on each counted second.
- game_over, output, 1, high in GAME_OVER.
- winner, output, 2, 00 not finished, 01 team1, 10 team2, 11 draw.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low (`rst_n`). All state is in the clk domain.
  - Reset values: state=IDLE, time_left=MATCH_SECONDS, scores 0, prescaler 0, pause counter 0.
  - All outputs are registered. Reset output values: playing=0, ball_reset=0, second_tick=0, game_over=0, winner=00.
- Goal edge detection:
  - Goal inputs are rising-edge detected against a registered copy; prev regs reset to 0.
  - A goal input held high counts once.
- Prescaler:
  - Counts 0..CLK_FREQ_HZ-1 only in PLAYING and GOAL_PAUSE.
  - The cycle at CLK_FREQ_HZ-1 is a tick and wraps to 0.
  - The prescaler is cleared on every state entry.
  - second_tick is registered from the tick, so it appears one cycle later.
- State IDLE:
  - start=1 → PLAYING.
  - Same edge: scores cleared, time_left=MATCH_SECONDS, ball_reset pulses for 1 cycle.
  - Goals are ignored.
- State PLAYING:
  - On a tick, time_left decrements.
  - Tick with time_left==1 → time_left=0, then GAME_OVER.
  - Goal edge → score +1, saturating at MAX_SCORE, then GOAL_PAUSE with ball_reset=1 for one cycle.
  - Both goal edges in the same cycle → both scores increment; one ball_reset pulse.
  - Goal and tick in the same cycle → both apply.
  - Exit priority: GAME_OVER (time 0 or any score reaching MAX_SCORE) over GOAL_PAUSE.
  - start is ignored.
- State GOAL_PAUSE:
  - playing=0 and time_left is frozen; ticks do not decrement it.
  - The pause counter counts ticks; after PAUSE_SECONDS ticks → PLAYING.
  - Goals and start are ignored.
- State GAME_OVER:
  - game_over=1 and playing=0.
  - winner is computed on entry and held: higher score wins, equal scores give 11.
  - start=1 → same action as from IDLE; winner returns to 00.
- Latency:
  - Score and playing outputs change on the clock edge after the cycle in which the goal edge is seen, i.e. 1 cycle after the input first goes high.
- Reset mid-operation:
  - Reset takes effect immediately and asynchronously to IDLE values.
  - Release is synchronous: the first active edge after rst_n rises sees IDLE.
- Widths:
  - Prescaler width is $clog2(CLK_FREQ_HZ).
  - time_left never underflows; 0 is only reachable via the GAME_OVER transition.

Decomposition:
- quidditch_pkg holds:
  - the match_state_t enum (IDLE, PLAYING, GOAL_PAUSE, GAME_OVER);
  - WINNER_NONE/T1/T2/DRAW 2-bit constants;
  - the default CLK_FREQ_HZ.
  - game_controller and vga_controller reuse it.
- One sub-module, second_prescaler:
  - parameter CLK_FREQ_HZ;
  - inputs clk, rst_n, enable, clear;
  - output tick.
  - The FSM, edge detectors and score/timer registers remain in match_clock_scorer.

Test Plan:
All scenarios use CLK_FREQ_HZ=10, MATCH_SECONDS=3, PAUSE_SECONDS=1, MAX_SCORE=2, SCORE_WIDTH=4.
- Reset/start: hold rst_n=0, then release and pulse start → time_left=3, playing=1, one ball_reset pulse; 10 cycles later time_left=2 and second_tick pulses once.
- Timeout: start, then no goals → after 30 cycles time_left=0, game_over=1, winner=11, playing=0.
- Goal pause: hold team1_goal high for 5 cycles in PLAYING → team1_points=1 exactly once, ball_reset one cycle, playing=0 for 10 cycles with time_left frozen, then playing=1.
- Simultaneous goals: team1_goal and team2_goal rise in the same cycle → both points=1, a single ball_reset, GOAL_PAUSE.
- Early win: two team2 goals separated by the pause → team2_points=2, game_over=1 immediately, winner=10, time_left frozen at its value.
- Reset and restart: assert rst_n=0 mid GOAL_PAUSE → all outputs at reset values within the same cycle; start in GAME_OVER → scores 0, time_left=3, winner=00.

Source files
------------

// File: rtl/quidditch_pkg.sv
// Shared match-level types and constants for the quidditch game pipeline.
// game_controller, match_clock_scorer and vga_controller all import this.
package quidditch_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PLAYING    = 2'd1,
    GOAL_PAUSE = 2'd2,
    GAME_OVER  = 2'd3
  } match_state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_T1   = 2'b01;
  localparam logic [1:0] WINNER_T2   = 2'b10;
  localparam logic [1:0] WINNER_DRAW = 2'b11;

  localparam int DEFAULT_CLK_FREQ_HZ = 50_000_000;

endpackage

// File: rtl/second_prescaler.sv
// Divides clk down to one tick per game second.
// tick is combinational so the FSM can act on it in the same cycle.
// clear has priority over enable so every state entry starts a fresh second.
module second_prescaler
  import quidditch_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_HZ - 1);

  logic [CW-1:0] count;

  // The last count of each second is the tick cycle.
  assign tick = enable && (count == LAST);

  // Count clk cycles while enabled, wrapping after the tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/match_clock_scorer.sv
// Match referee: keeps both scores, runs the match countdown, freezes play
// after each goal and declares the end of match and the winner.
// Every output is registered; next values are built in one combinational
// block and captured together with the state.
module match_clock_scorer
  import quidditch_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = DEFAULT_CLK_FREQ_HZ,
  parameter int MATCH_SECONDS = 90,
  parameter int PAUSE_SECONDS = 2,
  parameter int SCORE_WIDTH   = 4,
  parameter int MAX_SCORE     = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   team1_goal,
  input  logic                   team2_goal,
  output logic [7:0]             time_left,
  output logic [SCORE_WIDTH-1:0] team1_points,
  output logic [SCORE_WIDTH-1:0] team2_points,
  output logic                   playing,
  output logic                   ball_reset,
  output logic                   second_tick,
  output logic                   game_over,
  output logic [1:0]             winner
);

  localparam logic [SCORE_WIDTH-1:0] MAX_PTS    = SCORE_WIDTH'(MAX_SCORE);
  localparam logic [7:0]             START_TIME = 8'(MATCH_SECONDS);
  localparam int                     PW         = (PAUSE_SECONDS > 1) ? $clog2(PAUSE_SECONDS) : 1;
  localparam logic [PW-1:0]          PAUSE_LAST = PW'(PAUSE_SECONDS - 1);

  match_state_t state, state_next;

  logic                   team1_prev, team2_prev;
  logic                   team1_edge, team2_edge;
  logic                   tick;
  logic                   presc_enable, presc_clear;
  logic [PW-1:0]          pause_cnt, pause_next;
  logic [SCORE_WIDTH-1:0] team1_next, team2_next;
  logic [7:0]             time_next;
  logic                   ball_reset_next;
  logic [1:0]             winner_next;

  assign team1_edge   = team1_goal && !team1_prev;
  assign team2_edge   = team2_goal && !team2_prev;
  assign presc_enable = (state == PLAYING) || (state == GOAL_PAUSE);
  assign presc_clear  = (state_next != state);

  second_prescaler #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(presc_enable),
    .clear (presc_clear),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus next values of scores, timer, pause count and pulses.
  always_comb begin
    state_next      = state;
    team1_next      = team1_points;
    team2_next      = team2_points;
    time_next       = time_left;
    pause_next      = pause_cnt;
    ball_reset_next = 1'b0;
    winner_next     = winner;
    case (state)
      IDLE, GAME_OVER: begin
        if (start) begin
          state_next      = PLAYING;
          team1_next      = '0;
          team2_next      = '0;
          time_next       = START_TIME;
          pause_next      = '0;
          ball_reset_next = 1'b1;
          winner_next     = WINNER_NONE;
        end
      end
      PLAYING: begin
        if (team1_edge && (team1_points != MAX_PTS)) begin
          team1_next = team1_points + 1'b1;
        end
        if (team2_edge && (team2_points != MAX_PTS)) begin
          team2_next = team2_points + 1'b1;
        end
        if (tick && (time_left != 8'd0)) begin
          time_next = time_left - 8'd1;
        end
        if ((tick && (time_left == 8'd1)) || (team1_next == MAX_PTS) ||
            (team2_next == MAX_PTS)) begin
          state_next = GAME_OVER;
          if (team1_next > team2_next) begin
            winner_next = WINNER_T1;
          end else if (team2_next > team1_next) begin
            winner_next = WINNER_T2;
          end else begin
            winner_next = WINNER_DRAW;
          end
        end else if (team1_edge || team2_edge) begin
          state_next      = GOAL_PAUSE;
          pause_next      = '0;
          ball_reset_next = 1'b1;
        end
      end
      GOAL_PAUSE: begin
        if (tick) begin
          if (pause_cnt == PAUSE_LAST) begin
            state_next = PLAYING;
            pause_next = '0;
          end else begin
            pause_next = pause_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered outputs, scores, timer and goal edge-detector history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      team1_prev   <= 1'b0;
      team2_prev   <= 1'b0;
      team1_points <= '0;
      team2_points <= '0;
      time_left    <= START_TIME;
      pause_cnt    <= '0;
      playing      <= 1'b0;
      ball_reset   <= 1'b0;
      second_tick  <= 1'b0;
      game_over    <= 1'b0;
      winner       <= WINNER_NONE;
    end else begin
      team1_prev   <= team1_goal;
      team2_prev   <= team2_goal;
      team1_points <= team1_next;
      team2_points <= team2_next;
      time_left    <= time_next;
      pause_cnt    <= pause_next;
      playing      <= (state_next == PLAYING);
      ball_reset   <= ball_reset_next;
      second_tick  <= tick;
      game_over    <= (state_next == GAME_OVER);
      winner       <= winner_next;
    end
  end

endmodule

// File: tb/tb_match_clock_scorer.sv
// Directed bench for match_clock_scorer with a 10-cycle game second,
// 3-second match, 1-second goal pause and first-to-2 win.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_match_clock_scorer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       team1_goal = 1'b0;
  logic       team2_goal = 1'b0;
  logic [7:0] time_left;
  logic [3:0] team1_points;
  logic [3:0] team2_points;
  logic       playing;
  logic       ball_reset;
  logic       second_tick;
  logic       game_over;
  logic [1:0] winner;

  int checks = 0;
  int passes = 0;

  match_clock_scorer #(
    .CLK_FREQ_HZ  (10),
    .MATCH_SECONDS(3),
    .PAUSE_SECONDS(1),
    .SCORE_WIDTH  (4),
    .MAX_SCORE    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .team1_goal  (team1_goal),
    .team2_goal  (team2_goal),
    .time_left   (time_left),
    .team1_points(team1_points),
    .team2_points(team2_points),
    .playing     (playing),
    .ball_reset  (ball_reset),
    .second_tick (second_tick),
    .game_over   (game_over),
    .winner      (winner)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic g1, input logic g2);
    start      = s;
    team1_goal = g1;
    team2_goal = g2;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  task automatic checkIdleValues(input string tag);
    checkOutput({tag, "_time"},   int'(time_left), 3);
    checkOutput({tag, "_t1"},     int'(team1_points), 0);
    checkOutput({tag, "_t2"},     int'(team2_points), 0);
    checkOutput({tag, "_play"},   int'(playing), 0);
    checkOutput({tag, "_brst"},   int'(ball_reset), 0);
    checkOutput({tag, "_stick"},  int'(second_tick), 0);
    checkOutput({tag, "_over"},   int'(game_over), 0);
    checkOutput({tag, "_winner"}, int'(winner), 0);
  endtask

  // Watchdog so the run always ends even if the sequence stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(3);
    checkIdleValues("reset");
    rst_n = 1'b1;
    waitCycles(1);
    checkOutput("idle_after_release_play", int'(playing), 0);

    // Start: PLAYING, full time, one ball_reset pulse
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("start_play", int'(playing), 1);
    checkOutput("start_time", int'(time_left), 3);
    checkOutput("start_brst", int'(ball_reset), 1);
    waitCycles(1);
    checkOutput("start_brst_off", int'(ball_reset), 0);
    waitCycles(8);
    checkOutput("sec1_time_before", int'(time_left), 3);
    checkOutput("sec1_tick_before", int'(second_tick), 0);
    waitCycles(1);
    checkOutput("sec1_time", int'(time_left), 2);
    checkOutput("sec1_tick", int'(second_tick), 1);
    waitCycles(1);
    checkOutput("sec1_tick_off", int'(second_tick), 0);

    // Timeout with no goals: draw at 0-0
    waitCycles(18);
    checkOutput("tmo_time_before", int'(time_left), 1);
    checkOutput("tmo_over_before", int'(game_over), 0);
    waitCycles(1);
    checkOutput("tmo_time", int'(time_left), 0);
    checkOutput("tmo_over", int'(game_over), 1);
    checkOutput("tmo_winner", int'(winner), 3);
    checkOutput("tmo_play", int'(playing), 0);

    // Restart from GAME_OVER
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("restart_play", int'(playing), 1);
    checkOutput("restart_time", int'(time_left), 3);
    checkOutput("restart_winner", int'(winner), 0);
    checkOutput("restart_over", int'(game_over), 0);
    checkOutput("restart_brst", int'(ball_reset), 1);

    // Goal pause: team1_goal held high 5 cycles counts once
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(1);
    checkOutput("gp_t1", int'(team1_points), 1);
    checkOutput("gp_brst", int'(ball_reset), 1);
    checkOutput("gp_play", int'(playing), 0);
    waitCycles(1);
    checkOutput("gp_brst_off", int'(ball_reset), 0);
    waitCycles(3);
    checkOutput("gp_t1_held", int'(team1_points), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(5);
    checkOutput("gp_play_end", int'(playing), 0);
    checkOutput("gp_time_frozen", int'(time_left), 3);
    waitCycles(1);
    checkOutput("gp_resume", int'(playing), 1);
    checkOutput("gp_resume_time", int'(time_left), 3);

    // Early win: two team2 goals separated by the pause
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ew_t2_first", int'(team2_points), 1);
    checkOutput("ew_play_first", int'(playing), 0);
    checkOutput("ew_over_first", int'(game_over), 0);
    waitCycles(9);
    checkOutput("ew_pause_end", int'(playing), 0);
    waitCycles(1);
    checkOutput("ew_resume", int'(playing), 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCycles(1);
    checkOutput("ew_t2", int'(team2_points), 2);
    checkOutput("ew_over", int'(game_over), 1);
    checkOutput("ew_winner", int'(winner), 2);
    checkOutput("ew_play", int'(playing), 0);
    checkOutput("ew_time", int'(time_left), 3);
    waitCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ew_winner_hold", int'(winner), 2);
    checkOutput("ew_time_hold", int'(time_left), 3);

    // Simultaneous goals after a fresh start
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("sim_t1_clear", int'(team1_points), 0);
    checkOutput("sim_t2_clear", int'(team2_points), 0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("sim_t1", int'(team1_points), 1);
    checkOutput("sim_t2", int'(team2_points), 1);
    checkOutput("sim_brst", int'(ball_reset), 1);
    checkOutput("sim_play", int'(playing), 0);
    checkOutput("sim_over", int'(game_over), 0);
    waitCycles(1);
    checkOutput("sim_brst_off", int'(ball_reset), 0);

    // Asynchronous reset in the middle of GOAL_PAUSE
    rst_n = 1'b0;
    #1;
    checkIdleValues("midrst");
    waitCycles(1);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle_goal_ignored", int'(team1_points), 0);
    checkOutput("idle_play", int'(playing), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_start_play", int'(playing), 1);
    checkOutput("rst_start_time", int'(time_left), 3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
